// File: rtl/match_round_controller.sv
// Phase sequencer for a best-of-N fighting match: round reset, countdown, fight, scoring.
// Optional pause support is compiled in with `define PAUSE_EN.
//
// state       | meaning
// S_IDLE      | waiting for start, round_reset held high
// S_RESET     | round_reset pulse to physics/health blocks
// S_COUNTDOWN | pre-fight countdown, inputs gated
// S_FIGHT     | inputs live, clock running, health watched on ticks
// S_ROUND_END | dwell after a round result
// S_MATCH_END | final scene frozen until start
// S_PAUSED    | fight frozen (PAUSE_EN builds only)
module match_round_controller #(
  parameter int unsigned ROUNDS_TO_WIN   = 2,
  parameter int unsigned COUNTDOWN_TICKS = 60,
  parameter int unsigned ROUND_TICKS     = 1200,
  parameter int unsigned END_HOLD_TICKS  = 40,
  parameter int unsigned RESET_TICKS     = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick,
  input  logic        start_btn,
  input  logic        pause_btn,
  input  logic [8:0]  health_1,
  input  logic [8:0]  health_2,
  output logic        round_reset,
  output logic        input_enable,
  output logic [2:0]  phase,
  output logic [3:0]  countdown,
  output logic [10:0] time_left,
  output logic [1:0]  p1_rounds,
  output logic [1:0]  p2_rounds,
  output logic [1:0]  round_winner,
  output logic [1:0]  match_winner
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RESET     = 3'd1,
    S_COUNTDOWN = 3'd2,
    S_FIGHT     = 3'd3,
    S_ROUND_END = 3'd4,
    S_MATCH_END = 3'd5,
    S_PAUSED    = 3'd6
  } state_t;

  localparam logic [1:0] WIN       = 2'(ROUNDS_TO_WIN);
  localparam logic [1:0] RES_NONE  = 2'd0;
  localparam logic [1:0] RES_P1    = 2'd1;
  localparam logic [1:0] RES_P2    = 2'd2;
  localparam logic [1:0] RES_DRAW  = 2'd3;

  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [10:0] time_left_q, time_left_d;
  logic [1:0]  p1_q, p1_d, p2_q, p2_d;
  logic [1:0]  rw_q, rw_d, mw_q, mw_d;
  logic [3:0]  countdown_q, countdown_d;
  logic        round_reset_q, round_reset_d;
  logic        input_enable_q, input_enable_d;
  logic        start_prev_q;
  logic        start_edge, pause_edge;
  logic [10:0] time_dec;
  logic [1:0]  outcome;

  assign start_edge = start_btn & ~start_prev_q;

`ifdef PAUSE_EN
  logic pause_prev_q;
  assign pause_edge = pause_btn & ~pause_prev_q;
`else
  logic unused_pause;
  assign unused_pause = pause_btn;
  assign pause_edge   = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    time_left_d = time_left_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    rw_d        = rw_q;
    mw_d        = mw_q;
    outcome     = RES_NONE;
    time_dec    = (time_left_q == 11'd0) ? 11'd0 : time_left_q - 11'd1;

    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d     = S_RESET;
          cnt_d       = 11'(RESET_TICKS);
          time_left_d = 11'(ROUND_TICKS);
          p1_d        = 2'd0;
          p2_d        = 2'd0;
          rw_d        = RES_NONE;
          mw_d        = RES_NONE;
        end
      end
      S_RESET: begin
        if (tick) begin
          if (cnt_q <= 11'd1) begin
            state_d = S_COUNTDOWN;
            cnt_d   = 11'(COUNTDOWN_TICKS);
          end else begin
            cnt_d = cnt_q - 11'd1;
          end
        end
      end
      S_COUNTDOWN: begin
        if (tick) begin
          if (cnt_q <= 11'd1) begin
            state_d = S_FIGHT;
            cnt_d   = 11'd0;
          end else begin
            cnt_d = cnt_q - 11'd1;
          end
        end
      end
      S_FIGHT: begin
        if (pause_edge) begin
          state_d = S_PAUSED;
        end else if (tick) begin
          time_left_d = time_dec;
          // Simultaneous KO is a draw; single KO beats the clock; timeout compares health.
          if (health_1 == 9'd0 && health_2 == 9'd0) outcome = RES_DRAW;
          else if (health_2 == 9'd0)                outcome = RES_P1;
          else if (health_1 == 9'd0)                outcome = RES_P2;
          else if (time_dec == 11'd0) begin
            if (health_1 > health_2)      outcome = RES_P1;
            else if (health_2 > health_1) outcome = RES_P2;
            else                          outcome = RES_DRAW;
          end
          if (outcome != RES_NONE) begin
            state_d = S_ROUND_END;
            cnt_d   = 11'(END_HOLD_TICKS);
            rw_d    = outcome;
            if (outcome == RES_P1 && p1_q != 2'd3) p1_d = p1_q + 2'd1;
            if (outcome == RES_P2 && p2_q != 2'd3) p2_d = p2_q + 2'd1;
          end
        end
      end
      S_ROUND_END: begin
        if (tick) begin
          if (cnt_q <= 11'd1) begin
            if (p1_q == WIN || p2_q == WIN) begin
              state_d = S_MATCH_END;
              mw_d    = (p1_q == WIN) ? RES_P1 : RES_P2;
            end else begin
              state_d     = S_RESET;
              cnt_d       = 11'(RESET_TICKS);
              time_left_d = 11'(ROUND_TICKS);
            end
          end else begin
            cnt_d = cnt_q - 11'd1;
          end
        end
      end
      S_MATCH_END: begin
        if (start_edge) state_d = S_IDLE;
      end
`ifdef PAUSE_EN
      S_PAUSED: begin
        if (pause_edge) state_d = S_FIGHT;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    round_reset_d  = (state_d == S_IDLE) || (state_d == S_RESET);
    input_enable_d = (state_d == S_FIGHT);
    countdown_d    = (state_d == S_COUNTDOWN) ? 4'((12'(cnt_d) + 12'd19) / 12'd20) : 4'd0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= 11'd0;
      time_left_q    <= 11'd0;
      p1_q           <= 2'd0;
      p2_q           <= 2'd0;
      rw_q           <= RES_NONE;
      mw_q           <= RES_NONE;
      countdown_q    <= 4'd0;
      round_reset_q  <= 1'b1;
      input_enable_q <= 1'b0;
      start_prev_q   <= 1'b0;
`ifdef PAUSE_EN
      pause_prev_q   <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      time_left_q    <= time_left_d;
      p1_q           <= p1_d;
      p2_q           <= p2_d;
      rw_q           <= rw_d;
      mw_q           <= mw_d;
      countdown_q    <= countdown_d;
      round_reset_q  <= round_reset_d;
      input_enable_q <= input_enable_d;
      start_prev_q   <= start_btn;
`ifdef PAUSE_EN
      pause_prev_q   <= pause_btn;
`endif
    end
  end

  assign phase        = state_q;
  assign countdown    = countdown_q;
  assign time_left    = time_left_q;
  assign p1_rounds    = p1_q;
  assign p2_rounds    = p2_q;
  assign round_winner = rw_q;
  assign match_winner = mw_q;
  assign round_reset  = round_reset_q;
  assign input_enable = input_enable_q;

endmodule

// File: tb/tb_match_round_controller.sv
// Bench for match_round_controller: random tick spacing, health and outcomes vs a rule-level model.
module tb_match_round_controller;

  localparam int RTW = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tick = 1'b0;
  logic        start_btn = 1'b0;
  logic        pause_btn = 1'b0;
  logic [8:0]  health_1 = 9'd300;
  logic [8:0]  health_2 = 9'd300;
  logic        round_reset, input_enable;
  logic [2:0]  phase;
  logic [3:0]  countdown;
  logic [10:0] time_left;
  logic [1:0]  p1_rounds, p2_rounds, round_winner, match_winner;

  int errors = 0;
  int checks = 0;
  int exp_p1 = 0, exp_p2 = 0, exp_rw = 0, exp_mw = 0;

  always #5 clk = ~clk;

  match_round_controller dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .start_btn(start_btn), .pause_btn(pause_btn),
    .health_1(health_1), .health_2(health_2), .round_reset(round_reset),
    .input_enable(input_enable), .phase(phase), .countdown(countdown), .time_left(time_left),
    .p1_rounds(p1_rounds), .p2_rounds(p2_rounds), .round_winner(round_winner),
    .match_winner(match_winner)
  );

  // Idle 0..2 cycles, then a one-cycle tick; returns 1 time unit after the consuming edge.
  task automatic pulse_tick();
    int gap;
    gap = $urandom_range(0, 2);
    repeat (gap) begin @(posedge clk); #1; end
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
  endtask

  task automatic pulse_start();
    start_btn = 1'b1;
    @(posedge clk); #1;
    start_btn = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (phase !== 0) begin errors++; $display("FAIL rst_phase: got %0d want 0", phase); end
    checks++; if (round_reset !== 1'b1) begin errors++; $display("FAIL rst_round_reset: got %b want 1", round_reset); end
    checks++; if ({input_enable, countdown, time_left, p1_rounds, p2_rounds, round_winner, match_winner} !== '0) begin
      errors++; $display("FAIL rst_outputs: got ie=%b cd=%0d tl=%0d p1=%0d p2=%0d rw=%0d mw=%0d want all 0",
        input_enable, countdown, time_left, p1_rounds, p2_rounds, round_winner, match_winner);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      health_1 = 9'($urandom_range(0, 511));
      health_2 = 9'($urandom_range(0, 511));
      pulse_tick();
      checks++; if (phase !== 0 || round_reset !== 1'b1 || input_enable !== 1'b0) begin
        errors++; $display("FAIL idle_hold: got phase=%0d rr=%b ie=%b want 0,1,0", phase, round_reset, input_enable);
      end
      checks++; if (p1_rounds !== 0 || p2_rounds !== 0) begin
        errors++; $display("FAIL idle_scores: got %0d/%0d want 0/0", p1_rounds, p2_rounds);
      end
    end
  endtask

  task automatic check_started();
    checks++; if (phase !== 1 || round_reset !== 1'b1) begin
      errors++; $display("FAIL start_to_reset: got phase=%0d rr=%b want 1,1", phase, round_reset);
    end
    checks++; if (time_left !== 1200) begin errors++; $display("FAIL start_time_left: got %0d want 1200", time_left); end
    checks++; if (p1_rounds !== 0 || p2_rounds !== 0 || round_winner !== 0 || match_winner !== 0) begin
      errors++; $display("FAIL start_clear: got p1=%0d p2=%0d rw=%0d mw=%0d want 0", p1_rounds, p2_rounds, round_winner, match_winner);
    end
    exp_p1 = 0; exp_p2 = 0; exp_rw = 0; exp_mw = 0;
  endtask

  // One full round from RESET entry; ko_at=0 means the clock runs out at tick 1200.
  task automatic play_round(input int ko_at, input logic [8:0] h1_end, input logic [8:0] h2_end);
    int len;
    for (int i = 1; i <= 2; i++) begin
      health_1 = 9'($urandom_range(0, 511));
      health_2 = 9'($urandom_range(0, 511));
      pulse_tick();
      checks++; if (phase !== ((i < 2) ? 1 : 2)) begin errors++; $display("FAIL reset_len: tick %0d got phase %0d", i, phase); end
    end
    checks++; if (round_reset !== 1'b0 || countdown !== 3) begin
      errors++; $display("FAIL cd_entry: got rr=%b cd=%0d want 0,3", round_reset, countdown);
    end
    for (int i = 1; i <= 60; i++) begin
      if (i == 60) begin
        health_1 = 9'($urandom_range(1, 511));
        health_2 = 9'($urandom_range(1, 511));
      end else begin
        health_1 = 9'($urandom_range(0, 511));
        health_2 = 9'($urandom_range(0, 511));
      end
      pulse_tick();
      if (i < 60) begin
        checks++; if (phase !== 2 || input_enable !== 1'b0) begin
          errors++; $display("FAIL cd_phase: tick %0d got phase=%0d ie=%b want 2,0", i, phase, input_enable);
        end
        checks++; if (countdown !== (60 - i + 19) / 20) begin
          errors++; $display("FAIL cd_value: tick %0d got %0d want %0d", i, countdown, (60 - i + 19) / 20);
        end
      end else begin
        checks++; if (phase !== 3 || input_enable !== 1'b1 || countdown !== 0) begin
          errors++; $display("FAIL fight_entry: got phase=%0d ie=%b cd=%0d want 3,1,0", phase, input_enable, countdown);
        end
        checks++; if (time_left !== 1200) begin errors++; $display("FAIL fight_time0: got %0d want 1200", time_left); end
      end
    end
    len = (ko_at > 0) ? ko_at : 1200;
    for (int t = 1; t <= len; t++) begin
      if (t == len) begin
        health_1 = h1_end; health_2 = h2_end; start_btn = 1'b0;
      end else begin
        health_1 = 9'($urandom_range(1, 511));
        health_2 = 9'($urandom_range(1, 511));
        start_btn = 1'($urandom_range(0, 1));
      end
      pulse_tick();
      if (t < len) begin
        checks++; if (phase !== 3 || time_left !== 1200 - t) begin
          errors++; $display("FAIL fight_run: tick %0d got phase=%0d tl=%0d want 3,%0d", t, phase, time_left, 1200 - t);
        end
      end
    end
    if (h1_end == 0 && h2_end == 0) exp_rw = 3;
    else if (h2_end == 0)           exp_rw = 1;
    else if (h1_end == 0)           exp_rw = 2;
    else if (h1_end > h2_end)       exp_rw = 1;
    else if (h2_end > h1_end)       exp_rw = 2;
    else                            exp_rw = 3;
    if (exp_rw == 1 && exp_p1 < 3) exp_p1++;
    if (exp_rw == 2 && exp_p2 < 3) exp_p2++;
    checks++; if (phase !== 4 || input_enable !== 1'b0) begin
      errors++; $display("FAIL round_end: got phase=%0d ie=%b want 4,0", phase, input_enable);
    end
    checks++; if (round_winner !== exp_rw) begin errors++; $display("FAIL round_winner: got %0d want %0d", round_winner, exp_rw); end
    checks++; if (p1_rounds !== exp_p1 || p2_rounds !== exp_p2) begin
      errors++; $display("FAIL score: got %0d/%0d want %0d/%0d", p1_rounds, p2_rounds, exp_p1, exp_p2);
    end
    checks++; if (time_left !== 1200 - len) begin errors++; $display("FAIL end_time_left: got %0d want %0d", time_left, 1200 - len); end
    for (int i = 1; i <= 40; i++) begin
      health_1 = 9'($urandom_range(0, 511));
      health_2 = 9'($urandom_range(0, 511));
      pulse_tick();
      if (i < 40) begin
        checks++; if (phase !== 4) begin errors++; $display("FAIL end_hold: tick %0d got phase %0d want 4", i, phase); end
      end else if (exp_p1 == RTW || exp_p2 == RTW) begin
        exp_mw = (exp_p1 == RTW) ? 1 : 2;
        checks++; if (phase !== 5 || input_enable !== 1'b0 || round_reset !== 1'b0) begin
          errors++; $display("FAIL match_end: got phase=%0d ie=%b rr=%b want 5,0,0", phase, input_enable, round_reset);
        end
        checks++; if (match_winner !== exp_mw) begin errors++; $display("FAIL match_winner: got %0d want %0d", match_winner, exp_mw); end
      end else begin
        checks++; if (phase !== 1 || round_reset !== 1'b1 || time_left !== 1200) begin
          errors++; $display("FAIL next_round: got phase=%0d rr=%b tl=%0d want 1,1,1200", phase, round_reset, time_left);
        end
      end
    end
  endtask

  task automatic test_first_round();
    pulse_start();
    check_started();
    play_round($urandom_range(1, 120), 9'($urandom_range(1, 511)), 9'd0);
  endtask

  task automatic test_match_end();
    play_round($urandom_range(1, 120), 9'($urandom_range(1, 511)), 9'd0);
    for (int i = 0; i < 5; i++) begin
      health_1 = 9'($urandom_range(0, 511));
      health_2 = 9'($urandom_range(0, 511));
      pulse_tick();
      checks++; if (phase !== 5 || p1_rounds !== exp_p1 || match_winner !== exp_mw) begin
        errors++; $display("FAIL match_frozen: got phase=%0d p1=%0d mw=%0d want 5,%0d,%0d", phase, p1_rounds, match_winner, exp_p1, exp_mw);
      end
    end
    pulse_start();
    checks++; if (phase !== 0 || round_reset !== 1'b1) begin
      errors++; $display("FAIL back_to_idle: got phase=%0d rr=%b want 0,1", phase, round_reset);
    end
    pulse_start();
    check_started();
  endtask

  task automatic test_draws();
    play_round(0, 9'd100, 9'd100);
    play_round($urandom_range(1, 120), 9'd0, 9'd0);
  endtask

  task automatic test_random_match();
    int rounds;
    int kind;
    bit did_timeout;
    rounds = 0;
    did_timeout = 1'b0;
    while (exp_mw == 0 && rounds < 8) begin
      kind = $urandom_range(0, 2);
      if (kind == 2 && !did_timeout) begin
        did_timeout = 1'b1;
        play_round(0, 9'($urandom_range(1, 511)), 9'($urandom_range(1, 511)));
      end else if (kind == 1) begin
        play_round($urandom_range(1, 150), 9'd0, 9'($urandom_range(1, 511)));
      end else begin
        play_round($urandom_range(1, 150), 9'($urandom_range(1, 511)), 9'd0);
      end
      rounds++;
    end
    checks++; if (phase !== 5) begin errors++; $display("FAIL random_match_end: got phase %0d want 5", phase); end
  endtask

  task automatic test_pause();
    pulse_start();
    pulse_start();
    check_started();
    health_1 = 9'd300; health_2 = 9'd300;
    repeat (62) pulse_tick();
    checks++; if (phase !== 3) begin errors++; $display("FAIL pause_fight_entry: got phase %0d want 3", phase); end
`ifdef PAUSE_EN
    repeat (700) pulse_tick();
    checks++; if (time_left !== 500) begin errors++; $display("FAIL pause_tl_before: got %0d want 500", time_left); end
    pause_btn = 1'b1; @(posedge clk); #1; pause_btn = 1'b0;
    checks++; if (phase !== 6 || input_enable !== 1'b0) begin
      errors++; $display("FAIL paused: got phase=%0d ie=%b want 6,0", phase, input_enable);
    end
    health_2 = 9'd0;
    repeat (100) pulse_tick();
    checks++; if (phase !== 6 || time_left !== 500) begin
      errors++; $display("FAIL pause_frozen: got phase=%0d tl=%0d want 6,500", phase, time_left);
    end
    health_2 = 9'd300;
    pause_btn = 1'b1; @(posedge clk); #1; pause_btn = 1'b0;
    checks++; if (phase !== 3 || input_enable !== 1'b1 || time_left !== 500) begin
      errors++; $display("FAIL unpause: got phase=%0d ie=%b tl=%0d want 3,1,500", phase, input_enable, time_left);
    end
    pulse_tick();
    checks++; if (time_left !== 499) begin errors++; $display("FAIL resume_count: got %0d want 499", time_left); end
    pause_btn = 1'b1; @(posedge clk); #1; pause_btn = 1'b0;
    checks++; if (phase !== 6) begin errors++; $display("FAIL repause: got phase %0d want 6", phase); end
`else
    for (int i = 1; i <= 10; i++) begin
      pause_btn = 1'b1; @(posedge clk); #1; pause_btn = 1'b0;
      pulse_tick();
      checks++; if (phase !== 3 || time_left !== 1200 - i) begin
        errors++; $display("FAIL pause_ignored: got phase=%0d tl=%0d want 3,%0d", phase, time_left, 1200 - i);
      end
    end
`endif
    reset_n = 1'b0;
    #2;
    checks++; if (phase !== 0 || round_reset !== 1'b1 || input_enable !== 1'b0) begin
      errors++; $display("FAIL async_reset: got phase=%0d rr=%b ie=%b want 0,1,0", phase, round_reset, input_enable);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_first_round();
    test_match_end();
    test_draws();
    test_random_match();
    test_pause();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/match_round_controller.md
Name: match_round_controller

Overview:
- Phase sequencer for a best-of-N fighting match, on the 100 MHz system clock.
- Steps the game through idle, per-round reset, countdown, fight, round end and match end.
- Drives the round-reset line for the physics, collision and health blocks, and gates player inputs.
- Scores rounds from the two health values and exports phase, countdown and score for the 7-seg and OLED overlays.

Parameters:
ROUNDS_TO_WIN, 2, round wins that end the match (1..3)
COUNTDOWN_TICKS, 60, pre-fight countdown length in game ticks (3 s at 20 Hz)
ROUND_TICKS, 1200, fight time limit in ticks (60 s)
END_HOLD_TICKS, 40, dwell in ROUND_END before the next round
RESET_TICKS, 2, ticks round_reset stays asserted

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
tick  in  1  one-clk-wide game-tick enable, 20 Hz
start_btn  in  1  debounced start level
pause_btn  in  1  debounced pause level; used only with PAUSE_EN
health_1  in  9  player 1 health, 0 = KO
health_2  in  9  player 2 health
round_reset  out  1  reset to physics/health blocks, active high
input_enable  out  1  player movement/attack allowed
phase  out  3  0 IDLE, 1 RESET, 2 COUNTDOWN, 3 FIGHT, 4 ROUND_END, 5 MATCH_END, 6 PAUSED
countdown  out  4  whole seconds left in COUNTDOWN (3,2,1), else 0
time_left  out  11  fight ticks remaining
p1_rounds  out  2  rounds won by player 1
p2_rounds  out  2  rounds won by player 2
round_winner  out  2  last round result: 0 none, 1 P1, 2 P2, 3 draw
match_winner  out  2  0 none, 1 P1, 2 P2

Behaviour:
- Reset: async when reset_n = 0. Goes to IDLE and clears all counters and scores.
- Output reset values: round_reset = 1, input_enable = 0, phase = 0, and all other outputs 0.
- Registers: all outputs registered. Every state change and counter update takes effect on the clk edge after its cause.
- Start edge: detected on clk with a registered previous value of start_btn. It is acted on in any cycle, not only tick cycles.
- Counters: the tick counter advances only on cycles where tick = 1. Ticks arriving while round_reset is asserted still count.
- IDLE:
  - round_reset = 1.
  - Start edge → RESET; scores, round_winner and match_winner cleared.
- RESET:
  - round_reset = 1 for RESET_TICKS ticks, then → COUNTDOWN.
  - time_left is loaded with ROUND_TICKS on entry.
- COUNTDOWN:
  - round_reset = 0, input_enable = 0.
  - countdown = ceil(remaining/20).
  - After COUNTDOWN_TICKS ticks → FIGHT.
- FIGHT:
  - input_enable = 1.
  - time_left decrements each tick and saturates at 0.
  - Health is sampled on tick cycles. Outcome evaluated in this order:
    - health_1 = 0 and health_2 = 0 in the same sample: draw.
    - health_2 = 0 only: P1 wins the round.
    - health_1 = 0 only: P2 wins the round.
    - time_left reaches 0 with both players alive: higher health wins; equal health is a draw.
  - On any outcome → ROUND_END: set round_winner, increment the winner's score (saturating at 3), input_enable = 0.
- ROUND_END:
  - Hold END_HOLD_TICKS ticks.
  - If either score equals ROUNDS_TO_WIN → MATCH_END and set match_winner; otherwise → RESET.
  - A draw awards no point and the round is replayed.
- MATCH_END:
  - input_enable = 0, round_reset = 0; the final scene is frozen.
  - Start edge → IDLE.
- start_btn edges in RESET, COUNTDOWN, FIGHT and ROUND_END are ignored.
- Health changes outside FIGHT are ignored.
- Latency: from the KO tick sample, phase = 4 one clk later.

Optional Feature:
PAUSE_EN:
- Defined:
  - A pause_btn rising edge in FIGHT → PAUSED: input_enable = 0, time_left frozen, health not evaluated.
  - The next pause_btn edge → FIGHT with time_left unchanged.
  - reset_n while paused → IDLE.
- Undefined: pause_btn is ignored and phase never equals 6.

Test Plan:
- Reset released, no stimulus → phase 0, round_reset 1, input_enable 0, and all scores 0 indefinitely.
- Start pulse, both healths 300 → RESET for 2 ticks, COUNTDOWN showing 3, 2, 1 over 60 ticks, then FIGHT with input_enable 1 and time_left 1200 counting down.
- health_2 driven to 0 in FIGHT → ROUND_END next clk, round_winner 1, p1_rounds 1. After 40 ticks → RESET.
- P1 wins two rounds → MATCH_END with match_winner 1 and input_enable 0. Start edge → IDLE; next start clears the scores.
- Timeout with health_1 = 100, health_2 = 100 → round_winner 3, no score change, round replayed. Second check: both healths 0 in the same tick → draw.
- With PAUSE_EN: pause at time_left = 500, wait 100 ticks → time_left still 500. Unpause → countdown resumes. Assert reset_n mid-pause → phase 0.
